// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline-control definitions: opcodes, hazard FSM encoding,
// forward-select codes and the shadow-slot bit layout.
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } hz_state_e;

   // Codes name where the operand is taken from once the consumer is in EX.
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WD  = 2'b11;

   // Shadow slot layout, LSB first: memread, regwrite, rd[aw-1:0], valid (MSB).
   localparam int SLOT_MR = 0;
   localparam int SLOT_RW = 1;
   localparam int SLOT_RD = 2;

   function automatic int slot_width(input int aw);
      return aw + 3;
   endfunction

endpackage

// File: rtl/id_use_decode.sv
// Register-use decode for the instruction sitting in IF/ID.
// x0 is neither reported as a source nor as a destination.
module id_use_decode
   import riscv_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [31:0]       instr,
   input  logic              valid,
   output logic              use_rs1,
   output logic              use_rs2,
   output logic              regwrite,
   output logic              memread,
   output logic [REG_AW-1:0] rs1,
   output logic [REG_AW-1:0] rs2,
   output logic [REG_AW-1:0] rd
);

   logic rd1, rd2, wr, ld;
   logic unused_bits;

   assign rs1 = instr[15 +: REG_AW];
   assign rs2 = instr[20 +: REG_AW];
   assign rd  = instr[7 +: REG_AW];
   assign unused_bits = ^{instr[31:25], instr[14:12]};

   always_comb begin
      rd1 = 1'b0;
      rd2 = 1'b0;
      wr  = 1'b0;
      ld  = 1'b0;
      case (instr[6:0])
         OP_R:      begin rd1 = 1'b1; rd2 = 1'b1; wr = 1'b1; end
         OP_I:      begin rd1 = 1'b1; wr = 1'b1; end
         OP_LOAD:   begin rd1 = 1'b1; wr = 1'b1; ld = 1'b1; end
         OP_STORE:  begin rd1 = 1'b1; rd2 = 1'b1; end
         OP_BRANCH: begin rd1 = 1'b1; rd2 = 1'b1; end
         default:   ;
      endcase
   end

   assign use_rs1  = valid && rd1 && (rs1 != '0);
   assign use_rs2  = valid && rd2 && (rs2 != '0);
   assign regwrite = valid && wr && (rd != '0);
   assign memread  = regwrite && ld;

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: shadow EX/MEM/WB destination tracking, RAW stall,
// branch flush sequencing. Define FORWARDING_EN for load-use-only stalls plus fwd selects.
//
//  state | meaning
//  RUN   | normal issue; stall controls asserted in any cycle a hazard is seen
//  STALL | hazard held last cycle; IF/ID and PC frozen until it clears
//  FLUSH | cycle after a taken branch; ID content is wrong-path, never issued
module id_hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instruction_in,
   input  logic             id_valid,
   input  logic             ex_branch_taken,
   output logic             pc_write_en,
   output logic             ifid_write_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int SLOT_W = slot_width(REG_AW);
   localparam int SLOT_V = SLOT_W - 1;

   hz_state_e state_q, state_d;
   logic [SLOT_W-1:0] slot_ex, slot_mem, slot_wb, slot_id;
   logic use_rs1, use_rs2, regwrite, memread;
   logic [REG_AW-1:0] rs1, rs2, rd;
   logic raw, hazard, issue, stall_now;

   id_use_decode #(.REG_AW(REG_AW)) u_decode (
      .instr    (instruction_in),
      .valid    (id_valid),
      .use_rs1  (use_rs1),
      .use_rs2  (use_rs2),
      .regwrite (regwrite),
      .memread  (memread),
      .rs1      (rs1),
      .rs2      (rs2),
      .rd       (rd)
   );

   function automatic logic slot_hit(input logic [SLOT_W-1:0] s, input logic [REG_AW-1:0] r);
      return s[SLOT_V] && s[SLOT_RW] && (s[SLOT_RD +: REG_AW] == r);
   endfunction

   always_comb begin
      slot_id                     = '0;
      slot_id[SLOT_V]             = 1'b1;
      slot_id[SLOT_RD +: REG_AW]  = rd;
      slot_id[SLOT_RW]            = regwrite;
      slot_id[SLOT_MR]            = memread;
   end

`ifdef FORWARDING_EN
   // Only a load still in EX cannot be forwarded in time.
   assign raw = slot_ex[SLOT_MR] &&
                ((use_rs1 && slot_hit(slot_ex, rs1)) || (use_rs2 && slot_hit(slot_ex, rs2)));
`else
   // No regfile write-through, so a WB-stage producer still blocks the read.
   assign raw = (use_rs1 && (slot_hit(slot_ex, rs1) || slot_hit(slot_mem, rs1) || slot_hit(slot_wb, rs1))) ||
                (use_rs2 && (slot_hit(slot_ex, rs2) || slot_hit(slot_mem, rs2) || slot_hit(slot_wb, rs2)));
`endif

   assign hazard = raw && (state_q != ST_FLUSH);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (ex_branch_taken)        state_d = ST_FLUSH;
      else if (state_q == ST_FLUSH) state_d = ST_RUN;
      else if (hazard)            state_d = ST_STALL;
      else                        state_d = ST_RUN;
   end

   always_comb begin
      pc_write_en   = 1'b1;
      ifid_write_en = 1'b1;
      ifid_flush    = 1'b0;
      idex_bubble   = 1'b0;
      stall_now     = 1'b0;
      issue         = 1'b0;
      if (!reset) begin
         // hold reset values while reset is asserted
      end else if (ex_branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (state_q == ST_FLUSH) begin
         idex_bubble = 1'b1;
      end else if (hazard) begin
         pc_write_en   = 1'b0;
         ifid_write_en = 1'b0;
         idex_bubble   = 1'b1;
         stall_now     = 1'b1;
      end else begin
         issue = id_valid;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_ex      <= '0;
         slot_mem     <= '0;
         slot_wb      <= '0;
         stall_cycles <= '0;
      end else begin
         slot_wb  <= slot_mem;
         slot_mem <= slot_ex;
         slot_ex  <= issue ? slot_id : '0;
         if (stall_now && !(&stall_cycles))
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

`ifdef FORWARDING_EN
   function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] r);
      if (!used)                 return FWD_RF;
      if (slot_hit(slot_ex, r))  return FWD_MEM;
      if (slot_hit(slot_mem, r)) return FWD_WB;
      if (slot_hit(slot_wb, r))  return FWD_WD;
      return FWD_RF;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fwd_a <= FWD_RF;
         fwd_b <= FWD_RF;
      end else begin
         fwd_a <= issue ? fwd_sel(use_rs1, rs1) : FWD_RF;
         fwd_b <= issue ? fwd_sel(use_rs2, rs2) : FWD_RF;
      end
   end
`else
   assign fwd_a = FWD_RF;
   assign fwd_b = FWD_RF;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: directed pipeline scenarios plus random
// instruction streams, checked against a per-register last-writer age model.
module tb_id_hazard_ctrl;

`ifdef FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instruction_in = '0;
   logic        id_valid = 1'b0;
   logic        ex_branch_taken = 1'b0;
   logic        pc_write_en, ifid_write_en, ifid_flush, idex_bubble;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] stall_cycles;
   logic        s_pc, s_ifw, s_fl, s_bub;
   logic [1:0]  s_fa, s_fb;
   logic [7:0]  s_cnt;

   always #5 clk = ~clk;

   id_hazard_ctrl u_dut (
      .clk(clk), .reset(reset), .instruction_in(instruction_in), .id_valid(id_valid),
      .ex_branch_taken(ex_branch_taken), .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_cycles(stall_cycles)
   );

   // Narrow counter copy so saturation is reachable in a short run.
   id_hazard_ctrl #(.CNT_W(8)) u_sat (
      .clk(clk), .reset(reset), .instruction_in(instruction_in), .id_valid(id_valid),
      .ex_branch_taken(ex_branch_taken), .pc_write_en(s_pc), .ifid_write_en(s_ifw),
      .ifid_flush(s_fl), .idex_bubble(s_bub), .fwd_a(s_fa), .fwd_b(s_fb),
      .stall_cycles(s_cnt)
   );

   int n_chk = 0, n_pass = 0;
   int now;
   int last_wr[32];
   bit last_ld[32];
   bit flush_m, issued_m, last_ifw;
   int cnt16, cnt8;
   logic [1:0] efa, efb;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      else n_pass++;
   endtask

   function automatic logic [31:0] enc(input logic [6:0] f7, input int rd, input int rs1,
                                       input int rs2, input logic [6:0] op);
      logic [4:0] d, a, b;
      d = rd[4:0]; a = rs1[4:0]; b = rs2[4:0];
      return {f7, b, a, 3'b000, d, op};
   endfunction

   function automatic bit blocks(input int r);
      int age;
      if (r == 0) return 1'b0;
      age = now - last_wr[r];
      if (FWD) return (age == 1) && last_ld[r];
      return (age >= 1) && (age <= 3);
   endfunction

   function automatic logic [1:0] fcode(input bit used, input int r);
      if (!FWD || !used || r == 0) return 2'b00;
      case (now - last_wr[r])
         1: return 2'b10;
         2: return 2'b01;
         3: return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin last_wr[i] = -1000; last_ld[i] = 1'b0; end
      now = 0; flush_m = 1'b0; cnt16 = 0; cnt8 = 0; efa = 2'b00; efb = 2'b00;
      issued_m = 1'b0; last_ifw = 1'b1;
   endtask

   task automatic cyc(input logic [31:0] ins, input bit v, input bit br);
      bit r1, r2, w, ld, u1, u2, hz, stl;
      int a, b, d;
      logic [6:0] op;
      bit e_pc, e_ifw, e_fl, e_bub;
      instruction_in = ins; id_valid = v; ex_branch_taken = br;
      @(negedge clk);
      op = ins[6:0]; a = int'(ins[19:15]); b = int'(ins[24:20]); d = int'(ins[11:7]);
      r1 = 0; r2 = 0; w = 0; ld = 0;
      if (op == 7'b0110011) begin r1 = 1; r2 = 1; w = 1; end
      if (op == 7'b0010011) begin r1 = 1; w = 1; end
      if (op == 7'b0000011) begin r1 = 1; w = 1; ld = 1; end
      if (op == 7'b0100011 || op == 7'b1100011) begin r1 = 1; r2 = 1; end
      u1 = v && r1 && a != 0;
      u2 = v && r2 && b != 0;
      hz = (u1 && blocks(a)) || (u2 && blocks(b));
      stl = 0; issued_m = 0;
      if (br)           begin e_pc = 1; e_ifw = 1; e_fl = 1; e_bub = 1; end
      else if (flush_m) begin e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 1; end
      else if (hz)      begin e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 1; stl = 1; end
      else              begin e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; issued_m = v; end
      chk("pc_write_en", pc_write_en, e_pc);
      chk("ifid_write_en", ifid_write_en, e_ifw);
      chk("ifid_flush", ifid_flush, e_fl);
      chk("idex_bubble", idex_bubble, e_bub);
      chk("fwd_a", fwd_a, efa);
      chk("fwd_b", fwd_b, efb);
      chk("stall_cycles", stall_cycles, cnt16);
      chk("stall_cycles_w8", s_cnt, cnt8);
      if (stl) begin
         if (cnt16 < 65535) cnt16++;
         if (cnt8 < 255) cnt8++;
      end
      efa = issued_m ? fcode(u1, a) : 2'b00;
      efb = issued_m ? fcode(u2, b) : 2'b00;
      if (issued_m && w && d != 0) begin last_wr[d] = now; last_ld[d] = ld; end
      flush_m = br; last_ifw = e_ifw; now++;
   endtask

   task automatic adv();
      @(posedge clk); #1;
   endtask

   task automatic step(input logic [31:0] ins, input bit v, input bit br);
      cyc(ins, v, br); adv();
   endtask

   task automatic issue_wait(input logic [31:0] ins);
      for (int k = 0; k < 8; k++) begin
         step(ins, 1'b1, 1'b0);
         if (issued_m) return;
      end
      chk("issue_timeout", 32'd0, 32'd1);
   endtask

   task automatic reset_all();
      reset = 1'b0; id_valid = 1'b0; ex_branch_taken = 1'b0;
      @(posedge clk); #1;
      chk("rst_pc_write_en", pc_write_en, 1'b1);
      chk("rst_ifid_write_en", ifid_write_en, 1'b1);
      chk("rst_ifid_flush", ifid_flush, 1'b0);
      chk("rst_idex_bubble", idex_bubble, 1'b0);
      chk("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
      chk("rst_stall_cycles", stall_cycles, 16'd0);
      @(negedge clk); reset = 1'b1;
      model_reset();
      adv();
   endtask

   logic [31:0] add10, sub12, lw31, add5, addi0, add6, lw10, lw5, cur;
   logic [6:0]  ops [6];

   initial begin
      add10 = enc(7'h00, 10, 1, 2, 7'b0110011);
      sub12 = enc(7'h20, 12, 11, 10, 7'b0110011);
      lw31  = enc(7'h00, 31, 3, 6, 7'b0000011);
      add5  = enc(7'h00, 5, 31, 1, 7'b0110011);
      addi0 = enc(7'h00, 0, 0, 4, 7'b0010011);
      add6  = enc(7'h00, 6, 0, 0, 7'b0110011);
      lw10  = enc(7'h00, 10, 1, 0, 7'b0000011);
      lw5   = enc(7'h00, 5, 5, 0, 7'b0000011);
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111};
      model_reset();

      // back-to-back ALU dependency
      reset_all();
      issue_wait(add10);
      issue_wait(sub12);
      chk("addsub_fwd_b", fwd_b, FWD ? 2'b10 : 2'b00);
      chk("addsub_fwd_a", fwd_a, 2'b00);
      chk("addsub_stalls", stall_cycles, FWD ? 16'd1 - 16'd1 : 16'd3);
      step(32'd0, 1'b0, 1'b0);

      // load-use
      reset_all();
      issue_wait(lw31);
      issue_wait(add5);
      chk("loaduse_fwd_a", fwd_a, FWD ? 2'b01 : 2'b00);
      chk("loaduse_stalls", stall_cycles, FWD ? 16'd1 : 16'd3);
      step(32'd0, 1'b0, 1'b0);

      // x0 is never a dependency
      reset_all();
      issue_wait(addi0);
      issue_wait(add6);
      chk("x0_stalls", stall_cycles, 16'd0);
      chk("x0_fwd", {fwd_a, fwd_b}, 4'b0000);

      // taken branch while stalled
      reset_all();
      issue_wait(lw10);
      step(sub12, 1'b1, 1'b0);
      cyc(sub12, 1'b1, 1'b1);
      chk("br_ifid_flush", ifid_flush, 1'b1);
      chk("br_idex_bubble", idex_bubble, 1'b1);
      adv();
      cyc(sub12, 1'b0, 1'b0);
      chk("flush_bubble", idex_bubble, 1'b1);
      adv();
      cyc(add6, 1'b1, 1'b0);
      chk("after_flush_issue", idex_bubble, 1'b0);
      adv();
      chk("br_stalls", stall_cycles, 16'd1);

      // asynchronous reset in the middle of a stall
      reset_all();
      issue_wait(add10);
      cyc(sub12, 1'b1, 1'b0);
      chk("pre_rst_stalled", pc_write_en, FWD ? 1'b1 : 1'b0);
      #2 reset = 1'b0; ex_branch_taken = 1'b1;
      #1;
      chk("arst_pc_write_en", pc_write_en, 1'b1);
      chk("arst_ifid_write_en", ifid_write_en, 1'b1);
      chk("arst_ifid_flush", ifid_flush, 1'b0);
      chk("arst_idex_bubble", idex_bubble, 1'b0);
      chk("arst_stall_cycles", stall_cycles, 16'd0);
      chk("arst_fwd", {fwd_a, fwd_b}, 4'b0000);
      @(posedge clk); @(negedge clk);
      reset = 1'b1; ex_branch_taken = 1'b0;
      model_reset();
      adv();
      cyc(add6, 1'b1, 1'b0);
      chk("post_rst_no_stall", pc_write_en, 1'b1);
      adv();

      // replayed producer until the narrow counter saturates
      reset_all();
      for (int k = 0; k < 1200; k++) step(lw5, 1'b1, 1'b0);
      chk("sat_w8", s_cnt, 8'hFF);

      // random streams
      reset_all();
      cur = '0;
      for (int k = 0; k < 3000; k++) begin
         if (last_ifw)
            cur = enc(7'h00, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      ops[$urandom_range(0, 5)]);
         step(cur, $urandom_range(0, 4) != 0, $urandom_range(0, 19) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
Pipeline hazard controller for the ID stage of the 5-stage RV32I core. It decodes the instruction currently in IF/ID and tracks in-flight destination registers in an internal shadow pipeline (EX, MEM, WB slots). From these it drives stall, bubble and flush controls for PC, IF/ID and ID/EX. It sequences decode against register-file writeback and EX-resolved branches.

Parameters:
REG_AW, 5, register address width (32 architectural registers)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
instruction_in  in  32  instruction held in IF/ID
id_valid  in  1  IF/ID holds a real instruction
ex_branch_taken  in  1  branch in EX resolved taken (same-cycle)
pc_write_en  out  1  PC may advance
ifid_write_en  out  1  IF/ID may load
ifid_flush  out  1  clear IF/ID to invalid at next edge
idex_bubble  out  1  load NOP/invalid into ID/EX at next edge
fwd_a  out  2  rs1 forward select, registered with ID/EX (FWD build only, else 00)
fwd_b  out  2  rs2 forward select (as fwd_a)
stall_cycles  out  CNT_W  saturating count of STALL cycles

Behaviour:
- Decode by opcode [6:0]: 0110011 R reads rs1+rs2, writes rd. 0010011 I reads rs1, writes rd. 0000011 load reads rs1, writes rd, memread. 0100011 store reads rs1+rs2. 1100011 branch reads rs1+rs2. Other opcodes: no reads, no write.
- rd/rs == x0 is never a producer or consumer.
- Slot = {valid, rd, regwrite, memread}. Every edge: wb<=mem, mem<=ex.
- ex <= decoded ID instruction if id_valid && issue; otherwise ex <= invalid.
- hazard (combinational): a used rs matches a valid regwrite slot. Non-FWD: any of ex/mem/wb. FWD: see Optional Feature.
- FSM states RUN, STALL, FLUSH; state registered; controls combinational from state+inputs.
- RUN: ex_branch_taken -> FLUSH; else hazard -> STALL; else issue.
- STALL: pc_write_en=0, ifid_write_en=0, idex_bubble=1. Remains while hazard holds. Returns to RUN and issues in the first non-hazard cycle. ex_branch_taken -> FLUSH.
- FLUSH entry cycle (branch seen): ifid_flush=1, idex_bubble=1, pc_write_en=1.
- FLUSH: lasts one cycle; ID treated invalid (no hazard check, no issue), then RUN.
- Simultaneous branch_taken + hazard: flush wins; no stall and no counter increment.
- Branch taken also invalidates the ex slot entry being written that edge.
- Non-FWD worst-case stall: 3 cycles (producer immediately ahead). The regfile provides no internal write-read bypass.
- stall_cycles increments once per STALL-state cycle and saturates at all-ones.
- Reset (any time, including mid-stall): state=RUN, all slots invalid, stall_cycles=0, fwd_a/fwd_b=00, pc_write_en=1, ifid_write_en=1, ifid_flush=0, idex_bubble=0.
- Issue latency is 0 cycles when no hazard.

Optional Feature:
- FORWARDING_EN defined:
  - hazard applies only when the ex slot has memread and its rd matches a used rs (load-use, exactly 1 stall cycle).
  - fwd codes are computed at issue, youngest match first: ex slot -> 10 (from EX/MEM), mem slot -> 01 (from MEM/WB), wb slot -> 11 (WriteData bypass), none -> 00.
- FORWARDING_EN undefined:
  - full RAW stall on ex/mem/wb matches.
  - fwd_a/fwd_b tied 00 and no forwarding logic is synthesized.

Decomposition:
- Shared package riscv_pkg:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH).
  - FSM state encoding.
  - fwd select constants (FWD_RF, FWD_WB, FWD_MEM, FWD_WD).
  - shadow-slot field layout.
- One sub-module: id_use_decode. Combinational: instruction -> {use_rs1, use_rs2, regwrite, memread, rs1, rs2, rd}.
- The scoreboard shift and FSM stay in the top.

Test Plan:
- add x10,x1,x2 then sub x12,x11,x10 back-to-back:
  - Non-FWD: 3 STALL cycles, idex_bubble=1 for 3 cycles, stall_cycles=3.
  - FWD: no stall, fwd_b=10, fwd_a=00.
- lw x31,6(x3) then add x5,x31,x1, FWD: exactly 1 stall cycle, then issue with fwd_a=01; stall_cycles=1.
- addi x0,x0,4 followed by add x6,x0,x0: no stall in either build, fwd_a=fwd_b=00.
- Branch taken asserted during a STALL cycle: ifid_flush=1 and idex_bubble=1 that cycle, FLUSH for one cycle, then RUN; stall_cycles not incremented on the flush cycle.
- Reset deasserted->asserted mid-stall:
  - all outputs return to reset values asynchronously.
  - after release, the next independent instruction issues with no stall.
- Force 70000 consecutive hazard cycles (id_valid held, producer replayed): stall_cycles saturates at 16'hFFFF.
